uart_rx_ctrl: RTL and testbench

Receive-side controller for the UART receiver.
- Owns the receiver's parity configuration.
- Buffers received bytes, together with their parity-error flags, in a small show-ahead FIFO.
- Tracks overrun and parity-error statistics, and raises an interrupt on fill threshold, idle timeout or overrun.
- Sits between the receiver's DATA/EN/PARITY_ERR outputs and the CPU peripheral bus.

---
 rtl/uart_rx_ctrl.sv | 145 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller for the UART receiver.
// Owns the parity configuration and buffers received bytes with their
// parity-error flags in a show-ahead FIFO. It also tracks overrun,
// parity-error and idle-timeout status, and drives a registered IRQ.
module uart_rx_ctrl #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int THRESH  = 4,
    parameter int TIMEOUT = 400
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CFG_WE,
    input  logic [2:0]        CFG_WDATA,
    output logic              PARITY_EN,
    output logic              PARITY_ODD,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_EN,
    input  logic              RX_PERR,
    input  logic              RD,
    output logic [7:0]        RD_DATA,
    output logic              RD_PERR,
    output logic              EMPTY,
    output logic              FULL,
    output logic [ADDR_W:0]   COUNT,
    output logic              OVERRUN,
    output logic [7:0]        PERR_CNT,
    output logic              TIMEOUT_FLAG,
    input  logic              CLR_ERR,
    output logic              IRQ
);

    typedef struct packed {
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] THRESH_C = (ADDR_W+1)'(THRESH);
    localparam logic [15:0]     TMO_C    = 16'(TIMEOUT);

    rx_entry_t         mem [DEPTH];
    rx_entry_t         head;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_d;
    logic [15:0]       idle_q, idle_d;
    logic              flush, push, pop, ovr_evt, perr_evt;
    logic              idle_clr, tmo_hit, tmo_d, ovr_d;
    logic [7:0]        perr_d;

    // Flush wins over any same-cycle push or pop. A pop frees a slot, so a
    // push is accepted even while full.
    always_comb begin
        flush    = CFG_WE & CFG_WDATA[2];
        pop      = RD & ~EMPTY & ~flush;
        push     = RX_EN & ~flush & (~FULL | pop);
        ovr_evt  = RX_EN & ~flush & FULL & ~pop;
        perr_evt = RX_EN & RX_PERR;
    end

    // Next-state for occupancy, idle timer and sticky status.
    always_comb begin
        count_d = COUNT;
        if (flush)
            count_d = '0;
        else if (push & ~pop)
            count_d = COUNT + 1'b1;
        else if (pop & ~push)
            count_d = COUNT - 1'b1;

        idle_clr = push | pop | flush | EMPTY;
        tmo_hit  = 1'b0;
        idle_d   = idle_q;
        if (idle_clr) begin
            idle_d = '0;
        end else if (idle_q != TMO_C) begin
            idle_d  = idle_q + 16'd1;
            tmo_hit = (idle_d == TMO_C);
        end

        // A fresh event beats a concurrent clear.
        tmo_d = tmo_hit | (TIMEOUT_FLAG & ~(pop | flush | CLR_ERR));
        ovr_d = ovr_evt | (OVERRUN & ~CLR_ERR);

        perr_d = PERR_CNT;
        if (CLR_ERR)
            perr_d = {7'd0, perr_evt};
        else if (perr_evt && PERR_CNT != 8'hFF)
            perr_d = PERR_CNT + 8'd1;
    end

    // FIFO storage and pointers; pointers wrap naturally at DEPTH.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) mem[wr_ptr] <= '{perr: RX_PERR, data: RX_DATA};
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Registered status, config and IRQ. IRQ uses next-state values so it
    // lines up with the outputs it summarises.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            COUNT        <= '0;
            idle_q       <= '0;
            TIMEOUT_FLAG <= 1'b0;
            OVERRUN      <= 1'b0;
            PERR_CNT     <= '0;
            PARITY_EN    <= 1'b0;
            PARITY_ODD   <= 1'b0;
            IRQ          <= 1'b0;
        end else begin
            COUNT        <= count_d;
            idle_q       <= idle_d;
            TIMEOUT_FLAG <= tmo_d;
            OVERRUN      <= ovr_d;
            PERR_CNT     <= perr_d;
            if (CFG_WE) begin
                PARITY_EN  <= CFG_WDATA[0];
                PARITY_ODD <= CFG_WDATA[1];
            end
            IRQ <= (count_d >= THRESH_C) | tmo_d | ovr_d;
        end
    end

    // Show-ahead head entry, forced to zero while empty.
    always_comb begin
        EMPTY   = (COUNT == '0);
        FULL    = (COUNT == DEPTH_C);
        head    = mem[rd_ptr];
        RD_DATA = EMPTY ? 8'd0 : head.data;
        RD_PERR = EMPTY ? 1'b0 : head.perr;
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: scoreboard queue of expected FIFO
// entries plus a vector table for the fill/overrun/drain sequence.
module tb_uart_rx_ctrl;

    logic       CLK = 0, RESET_N = 0;
    logic       CFG_WE = 0, RX_EN = 0, RX_PERR = 0, RD = 0, CLR_ERR = 0;
    logic [2:0] CFG_WDATA = '0;
    logic [7:0] RX_DATA = '0;
    logic       PARITY_EN, PARITY_ODD, RD_PERR, EMPTY, FULL;
    logic       OVERRUN, TIMEOUT_FLAG, IRQ;
    logic [7:0] RD_DATA, PERR_CNT;
    logic [3:0] COUNT;

    uart_rx_ctrl #(.DEPTH(8), .ADDR_W(3), .THRESH(4), .TIMEOUT(400)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CFG_WE(CFG_WE), .CFG_WDATA(CFG_WDATA),
        .PARITY_EN(PARITY_EN), .PARITY_ODD(PARITY_ODD), .RX_DATA(RX_DATA),
        .RX_EN(RX_EN), .RX_PERR(RX_PERR), .RD(RD), .RD_DATA(RD_DATA),
        .RD_PERR(RD_PERR), .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT),
        .OVERRUN(OVERRUN), .PERR_CNT(PERR_CNT), .TIMEOUT_FLAG(TIMEOUT_FLAG),
        .CLR_ERR(CLR_ERR), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       perr;
        logic [7:0] data;
    } ent_t;

    typedef struct {
        logic       rx_en;
        logic [7:0] data;
        logic       rd;
        int         count;
        logic       full;
        logic       ovr;
        logic       irq;
    } vec_t;

    ent_t sb[$];
    vec_t vt[17];
    int   checks = 0, errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock of stimulus. The scoreboard checks popped data against the
    // queue head and checks COUNT against the queue depth after the edge.
    task automatic cyc(input logic rx_en, input logic [7:0] d, input logic perr,
                       input logic rd, input logic cfg_we, input logic [2:0] cfg,
                       input logic clr);
        int   sz;
        logic popped, fl;
        sz = sb.size();
        fl = cfg_we & cfg[2];
        popped = 0;
        RX_EN = rx_en; RX_DATA = d; RX_PERR = perr; RD = rd;
        CFG_WE = cfg_we; CFG_WDATA = cfg; CLR_ERR = clr;
        #1;
        if (rd && sz > 0 && !fl) begin
            chk("pop_data", RD_DATA, sb[0].data);
            chk("pop_perr", RD_PERR, sb[0].perr);
            void'(sb.pop_front());
            popped = 1;
        end
        if (rx_en && !fl && (sz < 8 || popped)) sb.push_back('{perr: perr, data: d});
        if (fl) sb.delete();
        @(posedge CLK); #1;
        RX_EN = 0; RD = 0; CFG_WE = 0; CLR_ERR = 0; RX_PERR = 0;
        chk("count", COUNT, sb.size());
    endtask

    initial begin
        int   k;
        logic [7:0] last;

        for (int i = 0; i < 9; i++)
            vt[i] = '{1'b1, 8'(i), 1'b0, (i < 8) ? i + 1 : 8, i >= 7, i == 8,
                      (i + 1 >= 4) || (i == 8)};
        for (int j = 0; j < 8; j++)
            vt[9 + j] = '{1'b0, 8'd0, 1'b1, 7 - j, 1'b0, 1'b1, 1'b1};

        // Reset values.
        #22 RESET_N = 1;
        @(posedge CLK); #1;
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_irq", IRQ, 0);
        chk("rst_perr_cnt", PERR_CNT, 0);
        chk("rst_pen", PARITY_EN, 0);
        chk("rst_rd_data", RD_DATA, 0);

        // Single byte in and out.
        cyc(1, 8'h41, 0, 0, 0, 3'b000, 0);
        chk("one_empty", EMPTY, 0);
        chk("one_data", RD_DATA, 8'h41);
        chk("one_perr", RD_PERR, 0);
        cyc(0, 0, 0, 1, 0, 3'b000, 0);
        chk("one_empty_after", EMPTY, 1);

        // Read while empty is ignored.
        cyc(0, 0, 0, 1, 0, 3'b000, 0);
        chk("rd_empty_ign", EMPTY, 1);

        // Fill, overrun, drain.
        foreach (vt[i]) begin
            cyc(vt[i].rx_en, vt[i].data, 0, vt[i].rd, 0, 3'b000, 0);
            chk($sformatf("vec%0d_count", i), COUNT, vt[i].count);
            chk($sformatf("vec%0d_full", i), FULL, vt[i].full);
            chk($sformatf("vec%0d_ovr", i), OVERRUN, vt[i].ovr);
            chk($sformatf("vec%0d_irq", i), IRQ, vt[i].irq);
        end
        cyc(0, 0, 0, 0, 0, 3'b000, 1);
        chk("clr_ovr", OVERRUN, 0);
        chk("clr_irq", IRQ, 0);

        // Push and pop with COUNT=1: the new byte becomes the head.
        cyc(1, 8'h21, 0, 0, 0, 3'b000, 0);
        cyc(1, 8'h22, 0, 1, 0, 3'b000, 0);
        chk("p1_head", RD_DATA, 8'h22);
        cyc(0, 0, 0, 1, 0, 3'b000, 0);

        // Full plus simultaneous push and pop: no overrun.
        for (int i = 0; i < 8; i++) cyc(1, 8'h10 + 8'(i), 0, 0, 0, 3'b000, 0);
        cyc(1, 8'h99, 0, 1, 0, 3'b000, 0);
        chk("fullrw_ovr", OVERRUN, 0);
        chk("fullrw_full", FULL, 1);
        last = 0;
        for (int i = 0; i < 8; i++) begin
            last = RD_DATA;
            cyc(0, 0, 0, 1, 0, 3'b000, 0);
        end
        chk("fullrw_last", last, 8'h99);

        // Parity config and error counter saturation.
        cyc(0, 0, 0, 0, 1, 3'b011, 0);
        chk("cfg_pen", PARITY_EN, 1);
        chk("cfg_podd", PARITY_ODD, 1);
        for (int i = 0; i < 300; i++) cyc(1, 8'(i), 1, 0, 0, 3'b000, 0);
        chk("perr_sat", PERR_CNT, 255);
        cyc(0, 0, 0, 0, 0, 3'b000, 1);
        chk("perr_clr", PERR_CNT, 0);
        cyc(1, 8'hAA, 1, 0, 0, 3'b000, 1);
        chk("perr_clr_evt", PERR_CNT, 1);
        chk("ovr_clr_evt", OVERRUN, 1);
        cyc(0, 0, 0, 0, 1, 3'b111, 1);
        chk("flush_empty", EMPTY, 1);
        chk("flush_pen", PARITY_EN, 1);
        chk("flush_ovr", OVERRUN, 0);

        // Idle timeout exactly TIMEOUT cycles after the push.
        cyc(1, 8'h77, 0, 0, 0, 3'b000, 0);
        chk("tmo_early", TIMEOUT_FLAG, 0);
        for (k = 1; k <= 1000; k++) begin
            @(posedge CLK); #1;
            if (TIMEOUT_FLAG) break;
        end
        chk("tmo_cycles", k, 400);
        chk("tmo_irq", IRQ, 1);
        cyc(0, 0, 0, 1, 0, 3'b000, 0);
        chk("tmo_clr", TIMEOUT_FLAG, 0);
        chk("tmo_irq_clr", IRQ, 0);

        // Flush concurrent with RX_EN discards the byte without overrun.
        for (int i = 0; i < 3; i++) cyc(1, 8'h30 + 8'(i), 0, 0, 0, 3'b000, 0);
        cyc(1, 8'h55, 0, 0, 1, 3'b100, 0);
        chk("flrx_empty", EMPTY, 1);
        chk("flrx_ovr", OVERRUN, 0);

        // Asynchronous reset mid-cycle.
        cyc(0, 0, 0, 0, 1, 3'b011, 0);
        cyc(1, 8'h66, 1, 0, 0, 3'b000, 0);
        cyc(1, 8'h67, 0, 0, 0, 3'b000, 0);
        #2 RESET_N = 0;
        #1;
        chk("arst_empty", EMPTY, 1);
        chk("arst_count", COUNT, 0);
        chk("arst_pen", PARITY_EN, 0);
        chk("arst_perr_cnt", PERR_CNT, 0);
        chk("arst_rd_data", RD_DATA, 0);
        sb.delete();
        @(negedge CLK) RESET_N = 1;
        @(posedge CLK); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
